// File: rtl/bcd_countdown.sv
// rtl/bcd_countdown.sv - presettable multi-digit BCD down-counter with expiry pulse
// Optional auto-reload on expiry: define BCD_COUNTDOWN_AUTO_RELOAD_EN.
module bcd_countdown #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  en,
   output logic [4*DIGITS-1:0]   count,
   output logic                  busy,
   output logic                  zero,
   output logic                  done,
   output logic                  load_err
);

   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0] ONE = W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   state_t         state, state_n;
   logic [W-1:0]   reload, reload_n, count_n;
   logic           done_n, load_err_n;

   // Ripple borrow: each digit at 0 wraps to 9 and passes the borrow upward.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic is_bcd(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   assign zero = (count == '0);
   assign busy = (state == RUN);

   always_comb begin
      state_n    = state;
      count_n    = count;
      reload_n   = reload;
      done_n     = 1'b0;
      load_err_n = 1'b0;
      if (load) begin
         if (is_bcd(load_val)) begin
            count_n  = load_val;
            reload_n = load_val;
            state_n  = IDLE;
         end else begin
            load_err_n = 1'b1;
         end
      end else begin
         case (state)
            IDLE: begin
               if (start && !zero) state_n = RUN;
            end
            RUN: begin
               if (stop) begin
                  state_n = IDLE;
               end else if (en) begin
                  if (count == ONE) begin
                     done_n = 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                     count_n = reload;
`else
                     count_n = '0;
                     state_n = EXPIRED;
`endif
                  end else begin
                     count_n = bcd_dec(count);
                  end
               end
            end
            EXPIRED: begin
               count_n = '0;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         reload   <= '0;
         done     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         state    <= state_n;
         count    <= count_n;
         reload   <= reload_n;
         done     <= done_n;
         load_err <= load_err_n;
      end
   end

endmodule

// File: tb/tb_bcd_countdown.sv
// tb/tb_bcd_countdown.sv - directed self-checking bench for bcd_countdown
// Auto-reload checks run when BCD_COUNTDOWN_AUTO_RELOAD_EN is defined.
module tb_bcd_countdown;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       en = 1'b0;
   logic [7:0] count;
   logic       busy, zero, done, load_err;

   int n_checks = 0;
   int n_pass   = 0;

   bcd_countdown #(.DIGITS(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .stop     (stop),
      .en       (en),
      .count    (count),
      .busy     (busy),
      .zero     (zero),
      .done     (done),
      .load_err (load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      load     = 1'b1;
      load_val = v;
      tick();
      load     = 1'b0;
   endtask

   initial begin
      tick();
      check("rst_count", count, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_zero", zero, 1'b1);
      check("rst_done", done, 1'b0);
      check("rst_lerr", load_err, 1'b0);
      rst = 1'b0;
      tick();

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
      begin
         logic [7:0] ar_exp [6];
         ar_exp = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03};
         do_load(8'h03);
         start = 1'b1;
         en    = 1'b1;
         tick();
         start = 1'b0;
         check("ar_start_busy", busy, 1'b1);
         for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("ar_count_%0d", i), count, ar_exp[i]);
            check($sformatf("ar_done_%0d", i), done, (ar_exp[i] == 8'h03) ? 1 : 0);
            check($sformatf("ar_busy_%0d", i), busy, 1'b1);
         end
         stop = 1'b1;
         tick();
         stop = 1'b0;
         en   = 1'b0;
         check("ar_stop_busy", busy, 1'b0);
         check("ar_stop_count", count, 8'h03);
      end
`else
      // Full countdown from 25: 25 edges to reach 00.
      do_load(8'h25);
      check("fc_load", count, 8'h25);
      start = 1'b1;
      en    = 1'b1;
      tick();
      start = 1'b0;
      check("fc_start_busy", busy, 1'b1);
      check("fc_start_count", count, 8'h25);
      for (int i = 0; i < 25; i++) begin
         int v;
         v = 24 - i;
         tick();
         check($sformatf("fc_count_%0d", v), count, ((v / 10) << 4) | (v % 10));
         check($sformatf("fc_done_%0d", v), done, (v == 0) ? 1 : 0);
         check($sformatf("fc_busy_%0d", v), busy, (v != 0) ? 1 : 0);
      end
      check("fc_zero", zero, 1'b1);
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      en    = 1'b0;
      check("exp_hold_count", count, 8'h00);
      check("exp_hold_done", done, 1'b0);
      check("exp_ignore_start", busy, 1'b0);
`endif

      // Rejected load leaves count alone; error flag pulses once.
      do_load(8'h12);
      check("rl_base", count, 8'h12);
      check("rl_base_err", load_err, 1'b0);
      do_load(8'h3A);
      check("rl_err", load_err, 1'b1);
      check("rl_keep", count, 8'h12);
      tick();
      check("rl_err_clear", load_err, 1'b0);
      do_load(8'h99);
      check("rl_ok_err", load_err, 1'b0);
      check("rl_ok_count", count, 8'h99);

      // Gated ticks, then stop and resume.
      do_load(8'h10);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("gt_busy", busy, 1'b1);
      check("gt_count0", count, 8'h10);
      for (int t = 0; t < 3; t++) begin
         en = 1'b1;
         tick();
         check($sformatf("gt_tick_%0d", t), count, 8'h09 - 8'(t));
         en = 1'b0;
         tick();
         tick();
         check($sformatf("gt_hold_%0d", t), count, 8'h09 - 8'(t));
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("ss_stop_busy", busy, 1'b0);
      check("ss_stop_count", count, 8'h07);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ss_resume_busy", busy, 1'b1);
      en = 1'b1;
      tick();
      check("ss_06", count, 8'h06);
      tick();
      check("ss_05", count, 8'h05);

      // Run down to 01, then collide final decrement with a load.
      for (int i = 0; i < 4; i++) tick();
      check("col_pre", count, 8'h01);
      load     = 1'b1;
      load_val = 8'h42;
      tick();
      load = 1'b0;
      en   = 1'b0;
      check("col_count", count, 8'h42);
      check("col_busy", busy, 1'b0);
      check("col_done", done, 1'b0);

      // Asynchronous reset between edges while running at 37.
      do_load(8'h37);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ar_pre_busy", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("arst_count", count, 8'h00);
      check("arst_busy", busy, 1'b0);
      check("arst_zero", zero, 1'b1);
      check("arst_done", done, 1'b0);
      #1 rst = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bcd_countdown.md
# bcd_countdown

Presettable multi-digit BCD down-counter/timer, the decrementing counterpart of the team's decade up-counter. It loads a decimal preset, counts down one step per enabled cycle with per-digit 0→9 borrow, and flags expiry with a single-cycle `done` pulse. It drives countdown displays and timeout sequencing alongside the existing decade counters.

## Interface
- `DIGITS`, default 2: number of BCD digits; count width is 4*DIGITS bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `load`  in  1  capture `load_val` into the count and reload registers.
- `load_val`  in  4*DIGITS  BCD preset; digit 0 is in bits [3:0].
- `start`  in  1  begin counting from IDLE.
- `stop`  in  1  abort RUN and return to IDLE, holding the count.
- `en`  in  1  count tick; one decrement per cycle with `en`=1 in RUN.
- `count`  out  4*DIGITS  current BCD value.
- `busy`  out  1  high while in RUN.
- `zero`  out  1  high when `count` is all zeros.
- `done`  out  1  one-cycle pulse on expiry.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- States: IDLE, RUN, EXPIRED. Reset: IDLE, `count`=0, reload=0, `busy`=0, `zero`=1, `done`=0, `load_err`=0.
- Per-cycle priority: `rst` > `load` > `stop` > `start` > `en` decrement.
- Load, any state. If every `load_val` nibble is ≤9, `count` and reload take `load_val` and the state becomes IDLE. If any nibble is >9, `count`, reload and state are unchanged and `load_err` pulses.
- IDLE: `start` with `count`≠0 moves to RUN. `start` with `count`=0 is ignored. `count` holds.
- RUN, `en`=0: hold.
- RUN, `en`=1, `count`>1: BCD decrement. Digit 0 decrements. Any digit at 0 wraps to 9 and borrows from the next digit.
- RUN, `en`=1, `count`=1: `count` becomes 0, the state moves to EXPIRED and `done` pulses.
- RUN, `stop`: move to IDLE and keep the current `count`. A later `start` resumes from that value.
- EXPIRED: `count`=0 is held. `start`, `stop` and `en` are ignored. Only `load` or `rst` exit this state.
- A `load` in the same cycle as the final decrement wins: `count`=`load_val`, IDLE, no `done`.
- Non-BCD values are never reachable in `count`.

## Timing
- All outputs are registered except `zero`, a combinational decode of the `count` register with no input-to-output path.
- `start` sampled at edge N: `busy`=1 after edge N. The first decrement happens at edge N+1 if `en`=1.
- Decrement latency is one cycle, from the `en` sample edge to the `count` update.
- `done` is high for exactly the one cycle in which `count` first reads 0 (or, with auto-reload, the reloaded value). `busy` falls on the same edge.
- A load takes effect on the sampling edge. `load_err` is high for the following cycle only.
- Asserting `rst` mid-operation forces all reset values immediately, without a clock edge. Deassertion is synchronized externally.
- A preset P with `en` held high reaches expiry P cycles after the first RUN edge.

## Configuration
- Macro `BCD_COUNTDOWN_AUTO_RELOAD_EN`.
- Defined: in RUN with `en`=1 and `count`=1, `count` takes the reload value, the state stays RUN and `done` pulses. `count` never shows 0 in RUN, and EXPIRED is unreachable. The counter runs until `stop` or `load`.
- Undefined: expiry enters EXPIRED as described above. The reload register is still written on load but is unused.

## Test plan
- Async reset mid-count: DIGITS=2, running at 0x37, pulse `rst` between clock edges. Required: `count`=0x00, `busy`=0, `zero`=1 and `done`=0 immediately.
- Full countdown: load 0x25, `start`, `en`=1 continuously. Required: 24, 23, …, 20, 19, …, 01, 00 over 25 edges. `done` is high only in the cycle `count`=00, `busy` falls together with it, and the state then holds at 00.
- Rejected load: while IDLE at 0x12, load 0x3A. Required: `load_err` is a one-cycle pulse and `count` stays 0x12. Then load 0x99 is accepted with no `load_err`.
- Gated ticks and stop/resume: load 0x10, `start`, `en` every third cycle. Required: 09 after the first tick, held between ticks. `stop` at 07 leaves IDLE at 07; `start` resumes 06, 05.
- Collision: in RUN at 0x01 with `en`=1, assert `load` with 0x42 in the same cycle. Required: `count`=0x42, IDLE, no `done`.
- With the macro defined: load 0x03, `start`, `en`=1. Required: 02, 01, 03, 02, 01, 03, with `done` pulsing on each reload and `busy` staying high. `stop` returns to IDLE holding the current value.
